stopwatch_ctrl: RTL and testbench

Input-conditioning and mode-control stage that sits directly upstream of the minutes/seconds counter. It synchronises and debounces the raw board buttons and switches, then runs a run/pause/adjust state machine. It drives the counter's run enable, clear, and adjust-mode inputs, and can optionally drive a blink flag for the display.

---
 rtl/stopwatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Button/switch conditioning (2-flop sync + debounce + press detect) and the
// run/pause/adjust mode FSM feeding the stopwatch counter. Optional display
// blink for adjust mode is compiled in with `define STOPWATCH_CTRL_BLINK_EN.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int BL_W            = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_rst,
  input  logic       btn_pause,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       run,
  output logic       clear,
  output logic       adj_mode,
  output logic       adj_sel,
  output logic       adj_blink,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    ADJUST  = 2'd3
  } state_t;

  localparam int NIN     = 4;
  localparam int I_RST   = 0;
  localparam int I_PAUSE = 1;
  localparam int I_ADJ   = 2;
  localparam int I_SEL   = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || (64'd1 << DB_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_db
    $error("stopwatch_ctrl: DEBOUNCE_CYCLES must be >= 1 and fit in DB_W bits");
  end
  if (BLINK_CYCLES < 1 || (64'd1 << BL_W) <= 64'(BLINK_CYCLES)) begin : g_bad_bl
    $error("stopwatch_ctrl: BLINK_CYCLES must be >= 1 and fit in BL_W bits");
  end

  logic [NIN-1:0]  raw, sync1, sync2, stable;
  logic [DB_W-1:0] db_cnt [NIN];
  logic [1:0]      stable_d;
  logic            rst_press, pause_press;
  state_t          state_q, state_n;
  logic            clear_n;

  assign raw = {sw_sel, sw_adj, btn_pause, btn_rst};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // NOTE: db_cnt is a handful of flops, not a RAM, so it takes the async reset
  // like any other register; a true memory array would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Registered rising-edge detect: one event per press, none on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d    <= '0;
      rst_press   <= 1'b0;
      pause_press <= 1'b0;
    end else begin
      stable_d    <= {stable[I_PAUSE], stable[I_RST]};
      rst_press   <= stable[I_RST] & ~stable_d[0];
      pause_press <= stable[I_PAUSE] & ~stable_d[1];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    clear_n = 1'b0;
    if (rst_press) begin
      state_n = IDLE;
      clear_n = 1'b1;
    end else begin
      case (state_q)
        IDLE, PAUSED: begin
          if (stable[I_ADJ])    state_n = ADJUST;
          else if (pause_press) state_n = RUNNING;
        end
        RUNNING: if (pause_press)     state_n = PAUSED;
        ADJUST:  if (!stable[I_ADJ])  state_n = PAUSED;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      clear    <= 1'b0;
      run      <= 1'b0;
      adj_mode <= 1'b0;
    end else begin
      state_q  <= state_n;
      clear    <= clear_n;
      run      <= (state_n == RUNNING);
      adj_mode <= (state_n == ADJUST);
    end
  end

  assign state   = state_q;
  assign adj_sel = stable[I_SEL] & adj_mode;

`ifdef STOPWATCH_CTRL_BLINK_EN
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);
  logic [BL_W-1:0] bl_cnt;
  logic            blink_q;

  // Counts only while staying in ADJUST, so entry starts from 0 and the
  // edge that leaves ADJUST also clears the blink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bl_cnt  <= '0;
      blink_q <= 1'b0;
    end else if (state_q == ADJUST && state_n == ADJUST) begin
      if (bl_cnt == BL_LAST) begin
        bl_cnt  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bl_cnt <= bl_cnt + BL_W'(1);
      end
    end else begin
      bl_cnt  <= '0;
      blink_q <= 1'b0;
    end
  end

  assign adj_blink = blink_q;
`else
  assign adj_blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, BLINK_CYCLES=3.
// A raw change driven just after edge N becomes stable after edge N+6, a press
// pulses after N+7 and state moves at N+8; a level (sw_adj) moves state at N+7.
module tb_stopwatch_ctrl;
  localparam int DEB       = 4;
  localparam int BLK       = 3;
  localparam int PRESS_LAT = DEB + 4;
  localparam int LEVEL_LAT = DEB + 3;
`ifdef STOPWATCH_CTRL_BLINK_EN
  localparam int BLINK_ON = 1;
`else
  localparam int BLINK_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_rst = 1'b0, btn_pause = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic       run, clear, adj_mode, adj_sel, adj_blink;
  logic [1:0] state;
  int         checks = 0;
  int         failures = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .DB_W(3), .BLINK_CYCLES(BLK), .BL_W(2)
  ) dut (
    .clk(clk), .reset(reset), .btn_rst(btn_rst), .btn_pause(btn_pause),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .run(run), .clear(clear),
    .adj_mode(adj_mode), .adj_sel(adj_sel), .adj_blink(adj_blink), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, pause, adj, sel;
    int         hold;
    logic [1:0] st;
    logic       run, mode, asel;
  } vec_t;

  vec_t vecs[14];
  int   blink_pat[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int r, input int c,
                            input int m, input int s);
    check({tag, ".state"},    int'(state),    st);
    check({tag, ".run"},      int'(run),      r);
    check({tag, ".clear"},    int'(clear),    c);
    check({tag, ".adj_mode"}, int'(adj_mode), m);
    check({tag, ".adj_sel"},  int'(adj_sel),  s);
  endtask

  initial begin
    // {rst, pause, adj, sel, hold, state, run, adj_mode, adj_sel}; starts in IDLE
    vecs[0]  = '{0, 1, 0, 0, 10, 2'd1, 1, 0, 0}; // IDLE -> RUNNING
    vecs[1]  = '{0, 0, 0, 0, 10, 2'd1, 1, 0, 0}; // release: no event
    vecs[2]  = '{0, 0, 1, 0, 10, 2'd1, 1, 0, 0}; // adj ignored while running
    vecs[3]  = '{0, 1, 1, 0, PRESS_LAT, 2'd2, 0, 0, 0}; // pause -> PAUSED
    vecs[4]  = '{0, 1, 1, 0, 1,  2'd3, 0, 1, 0}; // then ADJUST next edge
    vecs[5]  = '{0, 0, 1, 1, 10, 2'd3, 0, 1, 1}; // sel=1 -> adj_sel
    vecs[6]  = '{0, 1, 1, 1, 10, 2'd3, 0, 1, 1}; // pause ignored in ADJUST
    vecs[7]  = '{0, 0, 1, 0, 10, 2'd3, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 1, 10, 2'd3, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 1, 10, 2'd2, 0, 0, 0}; // adj off -> PAUSED, sel gated
    vecs[10] = '{0, 1, 0, 1, 10, 2'd1, 1, 0, 0}; // resume
    vecs[11] = '{0, 0, 0, 0, 10, 2'd1, 1, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 10, 2'd2, 0, 0, 0}; // pause again
    vecs[13] = '{0, 0, 0, 0, 10, 2'd2, 0, 0, 0};
    blink_pat = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

    // Reset / startup
    for (int t = 1; t <= 3; t++) begin
      tick();
      check_outs($sformatf("in_reset%0d", t), 0, 0, 0, 0, 0);
    end
    reset = 1'b0;
    tick();
    check_outs("after_reset", 0, 0, 0, 0, 0);
    check("after_reset.adj_blink", int'(adj_blink), 0);

    // Bounce rejection: 1-cycle pulses never survive the debounce
    for (int k = 0; k < 10; k++) begin
      btn_pause = 1'b1;
      tick();
      btn_pause = 1'b0;
      tick();
      check($sformatf("bounce%0d.state", k), int'(state), 0);
    end
    repeat (10) tick();
    check_outs("bounce_end", 0, 0, 0, 0, 0);

    // Start: held press gives exactly one event, state moves at edge 8
    btn_pause = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("start_t%0d.state", t), int'(state), (t >= PRESS_LAT) ? 1 : 0);
      check($sformatf("start_t%0d.run", t), int'(run), (t >= PRESS_LAT) ? 1 : 0);
    end
    btn_pause = 1'b0;
    repeat (10) tick();
    check_outs("start_release", 1, 1, 0, 0, 0);

    // Pause from RUNNING
    btn_pause = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check($sformatf("pause_t%0d.state", t), int'(state), (t >= PRESS_LAT) ? 2 : 1);
      check($sformatf("pause_t%0d.run", t), int'(run), (t >= PRESS_LAT) ? 0 : 1);
    end
    btn_pause = 1'b0;
    repeat (10) tick();

    // Clear from PAUSED: one-cycle clear pulse with the move to IDLE
    btn_rst = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check($sformatf("clr_t%0d.clear", t), int'(clear), (t == PRESS_LAT) ? 1 : 0);
      check($sformatf("clr_t%0d.state", t), int'(state), (t >= PRESS_LAT) ? 0 : 2);
    end
    btn_rst = 1'b0;
    repeat (10) tick();
    check_outs("clr_release", 0, 0, 0, 0, 0);

    // Table-driven mode walk
    for (int v = 0; v < 14; v++) begin
      btn_rst   = vecs[v].rst;
      btn_pause = vecs[v].pause;
      sw_adj    = vecs[v].adj;
      sw_sel    = vecs[v].sel;
      repeat (vecs[v].hold) tick();
      check_outs($sformatf("vec%0d", v), int'(vecs[v].st), int'(vecs[v].run), 0,
                 int'(vecs[v].mode), int'(vecs[v].asel));
    end

    // rst + pause together in PAUSED: clear wins, pause dropped
    btn_rst   = 1'b1;
    btn_pause = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check($sformatf("both_t%0d.clear", t), int'(clear), (t == PRESS_LAT) ? 1 : 0);
      check($sformatf("both_t%0d.state", t), int'(state), (t >= PRESS_LAT) ? 0 : 2);
    end
    btn_rst   = 1'b0;
    btn_pause = 1'b0;
    repeat (10) tick();
    check_outs("both_release", 0, 0, 0, 0, 0);

    // Adjust entry from IDLE and blink pattern
    sw_adj = 1'b1;
    for (int t = 1; t <= LEVEL_LAT + 9; t++) begin
      tick();
      check($sformatf("adj_t%0d.state", t), int'(state), (t >= LEVEL_LAT) ? 3 : 0);
      if (t >= LEVEL_LAT)
        check($sformatf("adj_t%0d.adj_blink", t), int'(adj_blink),
              BLINK_ON * blink_pat[t - LEVEL_LAT]);
      else
        check($sformatf("adj_t%0d.adj_blink", t), int'(adj_blink), 0);
    end

    // rst + pause in ADJUST: clear, IDLE and blink cleared on the same edge
    btn_rst   = 1'b1;
    btn_pause = 1'b1;
    for (int t = 1; t <= PRESS_LAT + 1; t++) begin
      tick();
      check($sformatf("prio_t%0d.clear", t), int'(clear), (t == PRESS_LAT) ? 1 : 0);
      check($sformatf("prio_t%0d.state", t), int'(state),
            (t == PRESS_LAT) ? 0 : 3);
      if (t == PRESS_LAT - 1)
        check("prio_pre.adj_blink", int'(adj_blink), BLINK_ON);
      if (t == PRESS_LAT)
        check("prio_edge.adj_blink", int'(adj_blink), 0);
    end
    btn_rst   = 1'b0;
    btn_pause = 1'b0;
    sw_adj    = 1'b0;
    repeat (10) tick();
    check_outs("prio_release", 2, 0, 0, 0, 0);

    // Reset mid-debounce aborts the in-progress count
    btn_pause = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_outs("abort_in_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int t = 1; t <= PRESS_LAT; t++) begin
      tick();
      check($sformatf("abort_t%0d.state", t), int'(state), (t >= PRESS_LAT) ? 1 : 0);
    end
    btn_pause = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
